// File: rtl/bcd_add_subtract_seq.sv
// bcd_add_subtract_seq: sequential add/subtract with double-dabble BCD conversion of the result magnitude.
module bcd_add_subtract_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  add_sub,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_result,
  output logic                  cout,
  output logic                  sign_flag
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int BW = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  generate
    if (WIDTH < 2 || pow10(DIGITS) <= (64'd1 << (WIDTH + 1)) - 64'd2) begin : g_bad_params
      $error("bcd_add_subtract_seq: WIDTH must be >= 2 and DIGITS must hold 2^(WIDTH+1)-2");
    end
  endgenerate

  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state, state_next;

  logic [WIDTH:0]    sr, sum, diff;
  logic [BW-1:0]     acc, adj;
  logic [BW+WIDTH:0] sh;
  logic [CW-1:0]     cnt;
  logic              cout_q, sign_q, lt, go, run, last;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    lt   = a < b;
    diff = lt ? {1'b0, b} - {1'b0, a} : {1'b0, a} - {1'b0, b};
    go   = state == IDLE && start && !enable;
    run  = state == CONVERT && !enable;
    last = run && cnt == CW'(1);
    state_next = go ? CONVERT : last ? IDLE : state;
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    sh = {adj, sr} << 1;
  end

  assign busy = state == CONVERT;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      acc        <= '0;
      cnt        <= '0;
      cout_q     <= 1'b0;
      sign_q     <= 1'b0;
      done       <= 1'b0;
      bcd_result <= '0;
      cout       <= 1'b0;
      sign_flag  <= 1'b0;
    end else begin
      done <= last;
      if (go) begin
        sr     <= add_sub ? diff : sum;
        acc    <= '0;
        cnt    <= CW'(WIDTH + 1);
        cout_q <= !add_sub && sum[WIDTH];
        sign_q <= add_sub && lt;
      end else if (run) begin
        acc <= sh[BW+WIDTH:WIDTH+1];
        sr  <= sh[WIDTH:0];
        cnt <= cnt - CW'(1);
        if (last) begin
          bcd_result <= sh[BW+WIDTH:WIDTH+1];
          cout       <= cout_q;
          sign_flag  <= sign_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_add_subtract_seq.sv
// tb_bcd_add_subtract_seq: directed checks of the default instance and a WIDTH=12/DIGITS=4 instance.
module tb_bcd_add_subtract_seq;
  logic clk = 0, rst_n = 0, enable = 0, start = 0, add_sub = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, cout, sign_flag;
  logic [11:0] bcd_result;
  logic start2 = 0;
  logic [11:0] a2 = 0, b2 = 0;
  logic busy2, done2, cout2, sign2;
  logic [15:0] bcd2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bcd_add_subtract_seq dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .a(a), .b(b),
    .add_sub(add_sub), .busy(busy), .done(done), .bcd_result(bcd_result),
    .cout(cout), .sign_flag(sign_flag)
  );

  bcd_add_subtract_seq #(.WIDTH(12), .DIGITS(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(1'b0), .start(start2), .a(a2), .b(b2),
    .add_sub(1'b0), .busy(busy2), .done(done2), .bcd_result(bcd2),
    .cout(cout2), .sign_flag(sign2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic op);
    a = x; b = y; add_sub = op; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [11:0] eb,
                           input logic ec, input logic es);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_bcd"}, bcd_result, eb);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_sign"}, sign_flag, es);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, dones;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_result, 0);
    chk("rst_flags", {cout, sign_flag}, 0);
    rst_n = 1;
    @(negedge clk);

    // start while disabled in IDLE must be ignored
    enable = 1; a = 8'd9; b = 8'd9; start = 1;
    @(negedge clk);
    chk("idle_disabled_busy", busy, 0);
    start = 0; enable = 0;
    @(negedge clk);
    chk("idle_disabled_busy2", busy, 0);

    start_op(8'd1, 8'd2, 0);
    chk("t1_busy", busy, 1);
    wait_done("t1", 9, 12'h003, 0, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    start_op(8'd1, 8'd2, 1);
    wait_done("t2a", 9, 12'h001, 0, 1);
    start_op(8'd150, 8'd75, 1);
    wait_done("t2b", 9, 12'h075, 0, 0);

    start_op(8'd255, 8'd255, 0);
    wait_done("t3a", 9, 12'h510, 1, 0);
    start_op(8'd0, 8'd255, 1);
    wait_done("t3b", 9, 12'h255, 0, 1);
    start_op(8'd37, 8'd37, 1);
    wait_done("t3c", 9, 12'h000, 0, 0);

    // stall 3 cycles and try to restart while busy
    start_op(8'd100, 8'd27, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) enable = 1;
      if (n == 3) chk("t4_busy_stall", busy, 1);
      if (n == 4) chk("t4_hold_bcd", bcd_result, 12'h000);
      if (n == 5) begin enable = 0; start = 1; a = 8'd9; end
      if (n == 6) start = 0;
    end while (!done && n < 50);
    chk("t4_latency", n, 12);
    chk("t4_bcd", bcd_result, 12'h127);
    @(negedge clk);
    chk("t4_no_restart", busy, 0);

    // async reset mid-operation
    start_op(8'd200, 8'd50, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("t5_bcd", bcd_result, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5_no_done", dones, 0);
    start_op(8'd1, 8'd2, 0);
    wait_done("t5_fresh", 9, 12'h003, 0, 0);

    // back-to-back: start accepted in the done cycle
    start_op(8'd1, 8'd2, 0);
    wait_done("t6a", 9, 12'h003, 0, 0);
    start_op(8'd5, 8'd5, 0);
    wait_done("t6b", 9, 12'h010, 0, 0);

    // wide instance
    a2 = 12'd4095; b2 = 12'd4095; start2 = 1;
    @(negedge clk);
    start2 = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done2 && n < 50);
    chk("t6w_latency", n, 13);
    chk("t6w_bcd", bcd2, 16'h8190);
    chk("t6w_cout", cout2, 1);
    chk("t6w_sign", sign2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
